// File: rtl/axi_simple_tx.sv
// axi_simple_tx: AXI-Stream word to MSB-first serial transmitter with generated sclk and inter-word gaps
module axi_simple_tx #(
    parameter int DATA_WIDTH     = 32,
    parameter int CLK_DIV        = 2,
    parameter int GAP_BITS       = 2,
    parameter int FRAME_GAP_BITS = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  sclk,
    output logic                  sdata,
    output logic                  svalid,
    output logic                  busy,
    output logic [15:0]           words_sent
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int GW = $clog2(FRAME_GAP_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t                state_q;
    logic [DW-1:0]         div_q, div_d;
    logic                  sclk_q, sclk_d;
    logic                  sdata_q, svalid_q, tready_q;
    logic                  hold_full_q, hold_full_d, hold_last_q, last_q;
    logic [DATA_WIDTH-1:0] hold_data_q, shift_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [GW-1:0]         gap_cnt_q;
    logic [15:0]           words_q;
    logic                  running, wrap, fall_tick, load, handshake;

    // Divider next state, fall_tick strobe and holding-register occupancy
    always_comb begin
        running     = enable || state_q != IDLE;
        wrap        = running && div_q == DW'(CLK_DIV - 1);
        fall_tick   = wrap && sclk_q;
        div_d       = (!running || wrap) ? '0 : div_q + 1'b1;
        sclk_d      = running && (wrap ? ~sclk_q : sclk_q);
        load        = fall_tick && enable && hold_full_q &&
                      (state_q == IDLE || (state_q == GAP && gap_cnt_q == '0));
        handshake   = s_axis_tvalid && tready_q;
        hold_full_d = handshake || (hold_full_q && !load);
    end

    // Transmit FSM: serial outputs and shifter only move on the sclk falling edge
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            sclk_q      <= 1'b0;
            sdata_q     <= 1'b0;
            svalid_q    <= 1'b0;
            tready_q    <= 1'b0;
            hold_full_q <= 1'b0;
            hold_last_q <= 1'b0;
            hold_data_q <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            last_q      <= 1'b0;
            words_q     <= '0;
        end else begin
            div_q       <= div_d;
            sclk_q      <= sclk_d;
            hold_full_q <= hold_full_d;
            tready_q    <= ~hold_full_d;
            if (handshake) begin
                hold_data_q <= s_axis_tdata;
                hold_last_q <= s_axis_tlast;
            end
            if (load) begin
                shift_q   <= hold_data_q;
                sdata_q   <= hold_data_q[DATA_WIDTH-1];
                svalid_q  <= 1'b1;
                bit_cnt_q <= BW'(DATA_WIDTH - 1);
                last_q    <= hold_last_q;
                state_q   <= SHIFT;
            end else if (fall_tick && state_q == SHIFT) begin
                if (bit_cnt_q == '0) begin
                    svalid_q  <= 1'b0;
                    sdata_q   <= 1'b0;
                    words_q   <= words_q + 1'b1;
                    gap_cnt_q <= last_q ? GW'(FRAME_GAP_BITS - 1) : GW'(GAP_BITS - 1);
                    state_q   <= GAP;
                end else begin
                    shift_q   <= shift_q << 1;
                    sdata_q   <= shift_q[DATA_WIDTH-2];
                    bit_cnt_q <= bit_cnt_q - 1'b1;
                end
            end else if (fall_tick && state_q == GAP) begin
                if (gap_cnt_q == '0) state_q <= IDLE;
                else gap_cnt_q <= gap_cnt_q - 1'b1;
            end
        end
    end

    assign s_axis_tready = tready_q;
    assign sclk          = sclk_q;
    assign sdata         = sdata_q;
    assign svalid        = svalid_q;
    assign busy          = state_q != IDLE || hold_full_q;
    assign words_sent    = words_q;
endmodule
